lnzd_mask_builder: RTL
======================

LNZD_MASK_BUILDER -- requirements
Module: lnzd_mask_builder

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 8, mask width; power of 2, >= 2.
REQ-002 SHALL derive POS_W = clog2(BIT_WIDTH) as a localparam, not a parameter.
REQ-003 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, position beat offered.
REQ-006 SHALL have port in_ready, output, 1, position beat accepted.
REQ-007 SHALL have port in_position, input, POS_W, bit index to set.
REQ-008 SHALL have port in_nz, input, 1, position meaningful; 0 = no nonzero (LNZD valid=0).
REQ-009 SHALL have port in_last, input, 1, final beat of frame.
REQ-010 SHALL have port out_valid, output, 1, reconstructed frame available.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts frame.
REQ-012 SHALL have port out_mask, output, BIT_WIDTH, reconstructed mask.
REQ-013 SHALL have port out_count, output, POS_W+1, number of distinct bits set.
REQ-014 SHALL have port out_dup, output, 1, frame contained a repeated position.

Function
REQ-015 SHALL implement two states, ACCUM and HOLD; reset state ACCUM.
REQ-016 In ACCUM: in_ready=1 and out_valid=0.
REQ-017 ACCUM input handshake with in_nz=1: set mask[in_position]; increment count only if that bit was previously 0.
REQ-018 Input handshake with in_nz=0: mask and count unchanged.
REQ-019 Handshake with in_last=1: go to HOLD; out_valid=1 on the next cycle (latency 1 cycle from last beat).
REQ-020 In HOLD: out_valid=1; out_mask, out_count and out_dup stable until the output handshake.
REQ-021 In HOLD: in_ready = out_ready (combinational).
REQ-022 Output handshake without a simultaneous input beat: clear mask, count and dup; go to ACCUM.
REQ-023 Output handshake with a simultaneous input beat: that beat is the first beat of the next frame.
  - it is applied to a cleared mask;
  - next state is HOLD if it carries in_last, otherwise ACCUM.
REQ-024 out_count SHALL not overflow: maximum value is BIT_WIDTH.
REQ-025 Outputs outside HOLD: out_valid=0; out_mask, out_count and out_dup show the accumulating values.

Reset
REQ-026 rst_n=0 at a clock edge SHALL force all of the following, including mid-frame or in HOLD:
  - state ACCUM;
  - out_mask=0, out_count=0, out_dup=0, out_valid=0;
  - partial frames discarded.
REQ-027 in_ready SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-028 Macro LNZD_MASK_DUP_CHECK_EN SHALL control duplicate detection.
  - Defined: a repeated in_nz=1 position within a frame sets a sticky dup flag, reported as out_dup with that frame.
  - Not defined: out_dup is tied to 0 and no dup flag register exists.
  - mask and count behaviour is identical in both builds.

Structure
REQ-029 Shared package lnzd_pkg SHALL hold the following; the module imports it and redefines none:
  - the clog2 function;
  - the ACCUM/HOLD state encoding typedef.
REQ-030 SHALL be a single module with no sub-module; count is tracked incrementally, not by popcount.

Verification (BIT_WIDTH=8)
REQ-031 Beats 1, 5, 7 (last) with in_nz=1 -> one cycle later out_valid=1, out_mask=0xA2, out_count=3, out_dup=0.
REQ-032 Single beat in_nz=0, in_last=1 -> out_valid=1, out_mask=0x00, out_count=0.
REQ-033 Beats 3, 3 (last) -> out_mask=0x08, out_count=1.
  - out_dup=1 with LNZD_MASK_DUP_CHECK_EN defined;
  - out_dup=0 without it.
REQ-034 Frame {6} held with out_ready=0 for 4 cycles: in_ready=0 and out_mask=0x40 stable throughout.
  - then out_ready=1 together with beat 2 (last) -> next frame out_mask=0x04, count=1, valid the following cycle.
REQ-035 Reset asserted after beat 4, before last; after release, beat 0 (last) -> out_mask=0x01, out_count=1.

Source files
------------

// File: rtl/lnzd_pkg.sv
// lnzd_pkg: shared definitions for the LNZD mask builder.
//   lnzd_state_e : ACCUM/HOLD state encoding of the frame builder.
//   clog2        : constant-evaluable ceiling log2, used to size
//                  position ports from the mask width.
package lnzd_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } lnzd_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/lnzd_mask_builder.sv
// lnzd_mask_builder: rebuilds a BIT_WIDTH-bit mask from a stream of bit
// positions (one LNZD result per beat), one frame per in_last.
//
// Ports:
//   clk         : sole clock, rising edge
//   rst_n       : synchronous active-low reset
//   in_valid    : position beat offered
//   in_ready    : position beat accepted (1 in ACCUM, out_ready in HOLD)
//   in_position : bit index to set
//   in_nz       : position meaningful; 0 = beat carries no nonzero bit
//   in_last     : final beat of the frame
//   out_valid   : reconstructed frame available (HOLD state)
//   out_ready   : consumer accepts frame
//   out_mask    : reconstructed mask (accumulating value outside HOLD)
//   out_count   : number of distinct bits set, saturates naturally at BIT_WIDTH
//   out_dup     : frame contained a repeated position
//
// Build option: define LNZD_MASK_DUP_CHECK_EN to enable the sticky
// duplicate-position flag; otherwise out_dup is tied to 0.
module lnzd_mask_builder
  import lnzd_pkg::*;
#(
  parameter  int unsigned BIT_WIDTH = 8,
  localparam int unsigned POS_W     = clog2(BIT_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [POS_W-1:0]     in_position,
  input  logic                 in_nz,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out_mask,
  output logic [POS_W:0]       out_count,
  output logic                 out_dup
);

  lnzd_state_e          state_q, state_n;
  logic                 valid_q;
  logic [BIT_WIDTH-1:0] mask_q, mask_n, base_mask, bit_sel;
  logic [POS_W:0]       count_q, count_n, base_count;
  logic                 in_hs, out_hs, bit_was_set;

  assign in_ready = (state_q == ACCUM) ? 1'b1 : out_ready;
  assign in_hs    = in_valid & in_ready;
  assign out_hs   = (state_q == HOLD) & out_ready;

  // A beat accepted in the same cycle as the output handshake starts the
  // next frame, so it is applied on top of the cleared accumulator.
  always_comb begin
    bit_sel              = '0;
    bit_sel[in_position] = 1'b1;
    base_mask            = out_hs ? '0 : mask_q;
    base_count           = out_hs ? '0 : count_q;
    bit_was_set          = |(base_mask & bit_sel);
    mask_n               = base_mask;
    count_n              = base_count;
    state_n              = out_hs ? ACCUM : state_q;
    if (in_hs) begin
      if (in_nz) begin
        mask_n = base_mask | bit_sel;
        if (!bit_was_set) count_n = base_count + (POS_W+1)'(1);
      end
      if (in_last) state_n = HOLD;
    end
  end

`ifdef LNZD_MASK_DUP_CHECK_EN
  logic dup_q, dup_n;

  always_comb begin
    dup_n = out_hs ? 1'b0 : dup_q;
    if (in_hs && in_nz && bit_was_set) dup_n = 1'b1;
  end

  assign out_dup = dup_q;
`else
  assign out_dup = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      valid_q <= 1'b0;
      mask_q  <= '0;
      count_q <= '0;
`ifdef LNZD_MASK_DUP_CHECK_EN
      dup_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      valid_q <= (state_n == HOLD);
      mask_q  <= mask_n;
      count_q <= count_n;
`ifdef LNZD_MASK_DUP_CHECK_EN
      dup_q   <= dup_n;
`endif
    end
  end

  assign out_valid = valid_q;
  assign out_mask  = mask_q;
  assign out_count = count_q;

endmodule
